// File: rtl/jk_reg_bank_if.sv
// Control/status bus of the JK register bank: update controls in, stored
// state and per-bit status flags out.
interface jk_reg_bank_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             ld;
    logic [WIDTH-1:0] ld_data;
    logic             clr_err;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic [WIDTH-1:0] changed;
    logic [WIDTH-1:0] err_sr;

    modport master (
        output en, mode, j, k, ld, ld_data, clr_err,
        input  q, qbar, changed, err_sr
    );

    modport slave (
        input  en, mode, j, k, ld, ld_data, clr_err,
        output q, qbar, changed, err_sr
    );
endinterface

// File: rtl/jk_reg_bank.sv
// Bank of edge-triggered JK-type flag bits with shared JK/SR/D/T mode,
// parallel load, change strobes and sticky SR-violation flags.
module jk_reg_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    jk_reg_bank_if.slave  bus
);
    typedef enum logic [1:0] {
        MODE_JK = 2'b00,
        MODE_SR = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_t;

    mode_t            mode_sel;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] changed_reg;
    logic [WIDTH-1:0] err_reg;
    logic [WIDTH-1:0] err_set;

    assign mode_sel = mode_t'(bus.mode);

    // Next-state decode: load beats enabled j/k operation; otherwise hold.
    always_comb begin
        q_next  = q_reg;
        err_set = '0;
        if (bus.ld) begin
            q_next = bus.ld_data;
        end else if (bus.en) begin
            for (int i = 0; i < WIDTH; i++) begin
                case (mode_sel)
                    MODE_JK: begin
                        case ({bus.j[i], bus.k[i]})
                            2'b01:   q_next[i] = 1'b0;
                            2'b10:   q_next[i] = 1'b1;
                            2'b11:   q_next[i] = ~q_reg[i];
                            default: q_next[i] = q_reg[i];
                        endcase
                    end
                    MODE_SR: begin
                        case ({bus.j[i], bus.k[i]})
                            2'b01:   q_next[i] = 1'b0;
                            2'b10:   q_next[i] = 1'b1;
                            2'b11:   err_set[i] = 1'b1;
                            default: q_next[i] = q_reg[i];
                        endcase
                    end
                    MODE_D: q_next[i] = bus.j[i];
                    MODE_T: q_next[i] = q_reg[i] ^ bus.j[i];
                endcase
            end
        end
    end

    // A same-edge violation wins over clr_err for its own bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg       <= RST_VAL;
            changed_reg <= '0;
            err_reg     <= '0;
        end else begin
            q_reg       <= q_next;
            changed_reg <= q_next ^ q_reg;
            err_reg     <= (bus.clr_err ? '0 : err_reg) | err_set;
        end
    end

    assign bus.q       = q_reg;
    assign bus.qbar    = ~q_reg;
    assign bus.changed = changed_reg;
    assign bus.err_sr  = err_reg;
endmodule

// File: doc/jk_reg_bank.md
# jk_reg_bank

Parametrised bank of WIDTH edge-triggered JK-type storage bits, the registered successor to the single-bit level-sensitive JK latch. Each bit is updated only on the rising clock edge. A shared 2-bit mode selects JK, SR, D or T interpretation of the per-bit j/k inputs. The bank adds a parallel load, a clock enable, a per-bit change strobe and sticky per-bit SR-violation flags. It serves as the general control/status flag register for sequential datapaths.

## Interface
- WIDTH, 8, number of storage bits (≥1)
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en  in  1  update enable for j/k/mode operation
- mode  in  2  00 JK, 01 SR, 10 D, 11 T
- j  in  WIDTH  per-bit J / S / D / T input
- k  in  WIDTH  per-bit K / R input (ignored in D and T modes)
- ld  in  1  parallel load strobe
- ld_data  in  WIDTH  parallel load value
- clr_err  in  1  clears all sticky error flags
- q  out  WIDTH  stored state
- qbar  out  WIDTH  always ~q, from the same register (never independently stored)
- changed  out  WIDTH  registered one-cycle pulse per bit that changed value on the previous edge
- err_sr  out  WIDTH  sticky per-bit flag: S=R=1 applied in SR mode while enabled

## Operation
- Priority per edge: rst > ld > en > hold.
- rst=1: q<=RST_VAL, changed<=0, err_sr<=0. All other inputs are ignored.
- ld=1 (rst=0): q<=ld_data regardless of en/mode. err_sr is not set by load.
- en=1, ld=0: per bit i, next q[i]:
  - JK: 00 hold, 01 clear, 10 set, 11 toggle.
  - SR (S=j, R=k): 00 hold, 01 clear, 10 set, 11 hold plus err_sr[i]<=1.
  - D: q[i]<=j[i].
  - T: j[i]=1 toggle, 0 hold.
- en=0, ld=0: q holds. mode/j/k are ignored and no error is raised.
- changed[i] <= (q_next[i] != q[i]) on every non-reset edge, so it is 0 on hold cycles.
- err_sr: sticky until rst or clr_err. When clr_err and a new violation occur on the same edge, set wins for the violating bits and all other bits clear.
- Update is edge-based. The value sampled is the input at the edge, so there is no race-through in toggle modes even when j=k=1 is held for many cycles.
- Bits are fully independent. There is no cross-bit coupling except the shared mode/en/ld.

## Timing
- All outputs are registered (except that qbar is an inverter on q). There are no combinational input-to-output paths.
- Latency: inputs at edge N are visible on q/qbar/changed/err_sr after edge N.
- Reset values: q=RST_VAL, qbar=~RST_VAL, changed=0, err_sr=0.
- Reset asserted mid-sequence takes effect at the next edge and overrides a simultaneous ld/en. changed does not pulse for the reset transition.
- A mode change takes effect on the same edge it is sampled. No pipeline or settling cycle is needed.
- Toggle held continuously (JK 11 or T 1, en=1): q alternates every edge and changed stays 1 for those bits.

## Test plan
- Reset, WIDTH=8, RST_VAL=8'hA5: hold rst 2 cycles, then release with en=0 -> q=A5, qbar=5A, changed=00, err_sr=00, holding across 3 further edges.
- JK truth table: q=00, mode=00, en=1, j=F0, k=0F -> q=F0, changed=F0. Next j=FF, k=FF -> q=0F, changed=FF. Next j=00, k=00 -> q=0F, changed=00.
- SR violation: q=00, mode=01, j=0C, k=0A -> q=04, err_sr=08. Then en=0 -> err_sr stays 08. clr_err with j=01, k=01, en=1 -> err_sr=01, q=04.
- D/T modes: mode=10, j=3C -> q=3C. mode=11, j=81 for 2 edges -> q=BD, then 3C. k is ignored throughout (driven random).
- Priority: ld=1, ld_data=55 with en=1, mode=11, j=FF -> q=55, not toggled. Same cycle with rst=1 -> q=RST_VAL, changed=00.
- Enable gating: en=0, random j/k/mode for 20 cycles -> q constant, changed=0, err_sr unchanged.
